mul_seq_16b: RTL and testbench



---
 rtl/mul_pkg.sv | 14 +
 rtl/cla_16b.sv | 45 ++++
 rtl/mul_seq_16b.sv | 117 +++++++++++
 tb/tb_mul_seq_16b.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding and sizing constants.
package mul_pkg;

    localparam int unsigned MUL_WIDTH     = 16;
    localparam int unsigned MUL_CNT_W     = 5;
    localparam int unsigned MUL_LAST_ITER = 15;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } mul_state_e;

endpackage

// File: rtl/cla_16b.sv
// 16-bit carry-lookahead adder: 4-bit groups with group-level lookahead, ripple inside each group.
module cla_16b (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);

    logic [15:0] gen;
    logic [15:0] prop;
    logic [3:0]  grp_gen;
    logic [3:0]  grp_prop;

    assign gen  = a_i & b_i;
    assign prop = a_i ^ b_i;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            grp_gen[k]  = gen[4*k+3]
                        | (prop[4*k+3] & gen[4*k+2])
                        | (prop[4*k+3] & prop[4*k+2] & gen[4*k+1])
                        | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & gen[4*k]);
            grp_prop[k] = &prop[4*k +: 4];
        end
    end

    always_comb begin
        logic grp_carry;
        logic bit_carry;
        sum_o     = '0;
        grp_carry = cin_i;
        for (int k = 0; k < 4; k++) begin
            bit_carry = grp_carry;
            for (int j = 0; j < 4; j++) begin
                sum_o[4*k+j] = prop[4*k+j] ^ bit_carry;
                bit_carry    = gen[4*k+j] | (prop[4*k+j] & bit_carry);
            end
            // Group carry comes from lookahead terms, not from the in-group ripple.
            grp_carry = grp_gen[k] | (grp_prop[k] & grp_carry);
        end
        cout_o = grp_carry;
    end

endmodule

// File: rtl/mul_seq_16b.sv
// Sequential unsigned 16x16->32 shift-add multiplier sharing one cla_16b over 16 iterations.
// Optional macro MUL_ZERO_BYPASS_EN: a zero operand skips the iterations and completes in 1 cycle.
module mul_seq_16b
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH,
    parameter int unsigned CNT_W = MUL_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    mul_state_e         state_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   acc_hi_q;
    logic [WIDTH-1:0]   acc_lo_q;
    logic [CNT_W-1:0]   count_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic [2*WIDTH-1:0] product_q;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic [2*WIDTH-1:0] acc_d;

    assign addend = acc_lo_q[0] ? mcand_q : '0;

    cla_16b u_cla (
        .a_i    (acc_hi_q),
        .b_i    (addend),
        .cin_i  (1'b0),
        .sum_o  (sum),
        .cout_o (cout)
    );

    // 33-bit {cout,sum,acc_lo} shifted right by one; cout lands in bit 31.
    assign acc_d = {cout, sum, acc_lo_q[WIDTH-1:1]};

`ifdef MUL_ZERO_BYPASS_EN
    logic zero_op;
    assign zero_op = (a_i == '0) || (b_i == '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            count_q   <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        mcand_q  <= a_i;
                        acc_hi_q <= '0;
                        acc_lo_q <= b_i;
                        count_q  <= '0;
                        ready_q  <= 1'b0;
`ifdef MUL_ZERO_BYPASS_EN
                        if (zero_op) begin
                            product_q <= '0;
                            state_q   <= StDone;
                            done_q    <= 1'b1;
                        end else begin
                            state_q <= StRun;
                            busy_q  <= 1'b1;
                        end
`else
                        state_q <= StRun;
                        busy_q  <= 1'b1;
`endif
                    end
                end
                StRun: begin
                    {acc_hi_q, acc_lo_q} <= acc_d;
                    count_q              <= count_q + 1'b1;
                    if (count_q == CNT_W'(MUL_LAST_ITER)) begin
                        product_q <= acc_d;
                        state_q   <= StDone;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o   = ready_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = product_q;

endmodule

// File: tb/tb_mul_seq_16b.sv
// Directed self-checking bench for mul_seq_16b with a queue scoreboard of expected products.
module tb_mul_seq_16b;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    mul_seq_16b dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
        .a_i       (a),
        .b_i       (b),
        .ready_o   (ready),
        .busy_o    (busy),
        .done_o    (done),
        .product_o (product)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_mul(input logic [15:0] x, input logic [15:0] y);
        logic [31:0] xx;
        logic [31:0] yy;
        xx = {16'h0, x};
        yy = {16'h0, y};
        return xx * yy;
    endfunction

    task automatic pop_check(input string tag);
        logic [31:0] exp;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp = sb.pop_front();
            check({tag, "_product"}, product, exp);
        end
    endtask

    // One start pulse; optional stray starts (a=1,b=1) at cycles 5 and 16 that must be ignored.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input int exp_lat, input bit noise);
        int lat;
        bit seen;
        sb.push_back(model_mul(av, bv));
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        seen  = 1'b0;
        lat   = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) check({tag, "_busy1"}, {31'b0, busy}, {31'b0, exp_lat > 1});
            if (done) begin
                seen = 1'b1;
                lat  = k;
            end
            if (noise && (k == 5 || k == 16)) begin
                start = 1'b1;
                a     = 16'd1;
                b     = 16'd1;
            end else begin
                start = 1'b0;
                a     = 16'($urandom);
                b     = 16'($urandom);
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        pop_check(tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        check({tag, "_ready_back"}, {31'b0, ready}, 32'd1);
    endtask

    initial begin
        int          cyc;
        int          ndone;
        int          last_done;
        int          accepts;
        bit          prev_ready;
        bit          held_ok;
        bit          seen_done;
        logic [31:0] prev_prod;
        logic [15:0] pa;
        logic [15:0] pb;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_product", product, 32'd0);
        rst = 1'b0;

        run_op("mul3x5", 16'd3, 16'd5, 17, 1'b0);
        run_op("mulmax", 16'hFFFF, 16'hFFFF, 17, 1'b0);
        run_op("ignore_start", 16'h1234, 16'h0100, 17, 1'b1);

        // Abort mid-run: no done pulse, reset values restored.
        @(negedge clk);
        start = 1'b1;
        a     = 16'd7;
        b     = 16'd9;
        repeat (8) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", {31'b0, ready}, 32'd1);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_product", product, 32'd0);
        seen_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        check("abort_no_done", {31'b0, seen_done}, 32'd0);

        // Reset and start together: reset wins, nothing accepted.
        rst   = 1'b1;
        start = 1'b1;
        a     = 16'd5;
        b     = 16'd5;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_ready", {31'b0, ready}, 32'd1);
        check("rst_start_busy", {31'b0, busy}, 32'd0);

        run_op("mul2x2", 16'd2, 16'd2, 17, 1'b0);
`ifdef MUL_ZERO_BYPASS_EN
        run_op("zero_op", 16'd0, 16'h55AA, 1, 1'b0);
`else
        run_op("zero_op", 16'd0, 16'h55AA, 17, 1'b0);
`endif

        // Back-to-back with start held high; next pair driven right after each accept.
        pa = 16'($urandom_range(1, 16'hFFFF));
        pb = 16'($urandom_range(1, 16'hFFFF));
        sb.push_back(model_mul(pa, pb));
        @(negedge clk);
        start      = 1'b1;
        a          = pa;
        b          = pb;
        prev_ready = ready;
        cyc        = 0;
        ndone      = 0;
        accepts    = 1;
        last_done  = -1;
        held_ok    = 1'b1;
        prev_prod  = product;
        while (ndone < 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                pop_check("b2b");
                if (last_done >= 0) check("b2b_interval", 32'(cyc - last_done), 32'd18);
                last_done = cyc;
                ndone++;
                prev_prod = product;
            end else if (ndone > 0 && product !== prev_prod) begin
                held_ok = 1'b0;
            end
            if (prev_ready && !ready) begin
                if (accepts < 4) begin
                    pa = 16'($urandom_range(1, 16'hFFFF));
                    pb = 16'($urandom_range(1, 16'hFFFF));
                    sb.push_back(model_mul(pa, pb));
                    a = pa;
                    b = pb;
                    accepts++;
                end else begin
                    start = 1'b0;
                end
            end
            prev_ready = ready;
        end
        start = 1'b0;
        check("b2b_count", 32'(ndone), 32'd4);
        check("b2b_held", {31'b0, held_ok}, 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
